// File: rtl/uart_hamming_transmitter.sv
// uart_hamming_transmitter: 7-bit UART frame serialiser with one-entry holding buffer.
// Define HAMMING_ENCODE_EN to Hamming(7,4)-encode data_in[3:0] at accept instead of sending data_in verbatim.
module uart_hamming_transmitter #(
  parameter int BIT_CLKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [6:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic [1:0] state_out
);
  localparam int CW = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [6:0] hold, shifter, shifter_n, code;
  logic hold_full, take, tx_n, last;
  logic [2:0] bit_cnt, bit_n;
  logic [CW-1:0] sample_cnt, sample_n;
`ifdef HAMMING_ENCODE_EN
  assign code = {data_in[3:1], data_in[1] ^ data_in[2] ^ data_in[3], data_in[0],
                 data_in[0] ^ data_in[2] ^ data_in[3], data_in[0] ^ data_in[1] ^ data_in[3]};
`else
  assign code = data_in;
`endif
  assign data_ready = ~hold_full;
  assign busy = state != IDLE;
  assign state_out = state;
  assign last = sample_cnt == LAST;
  // handshake runs every clk; the buffer only drains on an enabled load
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold <= '0;
      hold_full <= 1'b0;
    end else if (data_valid && !hold_full) begin
      hold <= code;
      hold_full <= 1'b1;
    end else if (ena && take) begin
      hold_full <= 1'b0;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shifter <= '0;
      bit_cnt <= '0;
      sample_cnt <= '0;
      tx <= 1'b1;
    end else if (ena) begin
      state <= state_n;
      shifter <= shifter_n;
      bit_cnt <= bit_n;
      sample_cnt <= sample_n;
      tx <= tx_n;
    end
  always_comb begin
    state_n = state;
    shifter_n = shifter;
    bit_n = bit_cnt;
    tx_n = tx;
    take = 1'b0;
    sample_n = last ? '0 : sample_cnt + 1'b1;
    case (state)
      IDLE: begin
        sample_n = '0;
        tx_n = 1'b1;
        if (hold_full) begin
          take = 1'b1;
          state_n = START;
          shifter_n = hold;
          tx_n = 1'b0;
        end
      end
      START: if (last) begin
        tx_n = shifter[0];
        bit_n = '0;
        state_n = DATA;
      end
      DATA: if (last) begin
        if (bit_cnt == 3'd6) begin
          tx_n = 1'b1;
          state_n = STOP;
        end else begin
          shifter_n = shifter >> 1;
          tx_n = shifter[1];
          bit_n = bit_cnt + 1'b1;
        end
      end
      STOP: if (last) begin
        take = hold_full;
        state_n = hold_full ? START : IDLE;
        shifter_n = hold_full ? hold : shifter;
        tx_n = ~hold_full;
      end
      default: begin
        state_n = IDLE;
        tx_n = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_hamming_transmitter.sv
// tb_uart_hamming_transmitter: scoreboard bench decoding tx cycle by cycle against queued expected words.
module tb_uart_hamming_transmitter;
  logic clk, rst, ena, data_valid, data_ready, tx, busy, tog;
  logic [6:0] data_in;
  logic [1:0] state_out;
  logic [6:0] exp_q[$];
  int checks = 0, fails = 0;
  uart_hamming_transmitter #(.BIT_CLKS(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .tx(tx), .busy(busy), .state_out(state_out)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    ena = 1'b1;
    forever @(negedge clk) ena = tog ? ~ena : 1'b1;
  end
  function automatic logic [6:0] model(input logic [6:0] d);
`ifdef HAMMING_ENCODE_EN
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
`else
    return d;
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [6:0] d);
    int n = 0;
    data_in = d;
    data_valid = 1'b1;
    while (data_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", n < 400, 1);
    if (n < 400) exp_q.push_back(model(d));
    @(negedge clk);
    data_valid = 1'b0;
  endtask
  task automatic check_frame(input int bl, output int waited);
    logic [6:0] w;
    logic e;
    waited = 0;
    while (tx !== 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    chk("start_found", waited < 400, 1);
    chk("sb_nonempty", exp_q.size() != 0, 1);
    if (waited >= 400 || exp_q.size() == 0) return;
    w = exp_q.pop_front();
    for (int c = 0; c < 9 * bl; c++) begin
      if (c > 0) @(negedge clk);
      e = (c / bl == 0) ? 1'b0 : (c / bl == 8) ? 1'b1 : w[c / bl - 1];
      chk($sformatf("tx w=%0h c=%0d", w, c), tx, e);
      chk($sformatf("busy c=%0d", c), busy, 1);
    end
  endtask
  initial begin
    int g, g2, n;
    tog = 1'b0;
    rst = 1'b1;
    data_valid = 1'b0;
    data_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", data_ready, 1);
    chk("rst_state", state_out, 0);
    rst = 1'b0;
    @(negedge clk);
    // single frame, then line must be idle exactly after 72 busy cycles
    send(7'h55);
    check_frame(8, g);
    @(negedge clk);
    chk("s1_busy_end", busy, 0);
    chk("s1_tx_end", tx, 1);
    chk("s1_state_end", state_out, 0);
    // back-to-back frames; buffer stays full and ignores data_in changes meanwhile
    fork
      begin
        send(7'h01);
        send(7'h7E);
        for (int i = 0; i < 20; i++) begin
          data_in = 7'($urandom);
          data_valid = 1'b1;
          @(negedge clk);
          chk("s5_ready_low", data_ready, 0);
        end
        data_valid = 1'b0;
      end
      begin
        check_frame(8, g);
        check_frame(8, g2);
        chk("s2_no_gap", g2, 1);
        chk("s2_ready_back", data_ready, 1);
      end
    join
    repeat (3) @(negedge clk);
    chk("s2_idle", busy, 0);
    // half-rate enable stretches each bit to 16 clocks
    tog = 1'b1;
    send(7'h2A);
    check_frame(16, g);
    tog = 1'b0;
    repeat (4) @(negedge clk);
    chk("s3_idle", state_out, 0);
    // async reset in the middle of data bit 3
    send(7'h55);
    n = 0;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("s4_start", n < 400, 1);
    repeat (36) @(negedge clk);
    chk("s4_bit3_low", tx, 0);
    chk("s4_in_data", state_out, 2);
    rst = 1'b1;
    #1;
    chk("s4_rst_tx", tx, 1);
    chk("s4_rst_state", state_out, 0);
    chk("s4_rst_ready", data_ready, 1);
    chk("s4_rst_busy", busy, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(7'h33);
    check_frame(8, g);
`ifdef HAMMING_ENCODE_EN
    // upper bits must be ignored; 4'b1011 encodes to 7'h55
    send(7'b1111011);
    check_frame(8, g);
`endif
    repeat (2) @(negedge clk);
    chk("final_idle", busy, 0);
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
